// File: rtl/alu_pipe.sv
// Pipelined CCU ALU: valid/ready operand intake, registered held result, optional
// iterative multiply/divide (ops 8/9) enabled by defining ALU_PIPE_MULDIV_EN.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [3:0]       cc,
  output logic             write_enable,
  output logic             err
);

`ifdef ALU_PIPE_MULDIV_EN
  typedef enum logic [1:0] {IDLE, ITER, HOLD} state_e;
`else
  typedef enum logic {IDLE, HOLD} state_e;
`endif

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [3:0]       cc_q, cc_d;
  logic             err_q, err_d;
  logic             accept;
  logic [WIDTH-1:0] sc_r;
  logic [3:0]       sc_cc;
  logic             sc_err;

`ifdef ALU_PIPE_MULDIV_EN
  // acc: product accumulator (mul) or partial remainder (div);
  // opnd: shifted multiplicand or divisor; shf: multiplier or dividend/quotient.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, opnd_q, opnd_d, shf_q, shf_d;
  logic             div_q, div_d;
  logic [WIDTH-1:0] acc_nx, opnd_nx, shf_nx, it_res;
  logic [WIDTH:0]   rem_sh;
  logic             start_iter;

  assign start_iter = (op == 4'd8) || (op == 4'd9);

  always_comb begin
    rem_sh  = {acc_q, shf_q[WIDTH-1]};
    acc_nx  = acc_q;
    opnd_nx = opnd_q;
    shf_nx  = shf_q;
    if (div_q) begin
      if (rem_sh >= {1'b0, opnd_q}) begin
        acc_nx = WIDTH'(rem_sh - {1'b0, opnd_q});
        shf_nx = {shf_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = WIDTH'(rem_sh);
        shf_nx = {shf_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nx  = shf_q[0] ? acc_q + opnd_q : acc_q;
      shf_nx  = {1'b0, shf_q[WIDTH-1:1]};
      opnd_nx = {opnd_q[WIDTH-2:0], 1'b0};
    end
    it_res = div_q ? shf_nx : acc_nx;
  end
`endif

  assign in_ready     = ~rst & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign accept       = in_valid & in_ready;
  assign out_valid    = out_valid_q;
  assign r            = r_q;
  assign cc           = cc_q;
  assign err          = err_q;
  assign write_enable = out_valid_q & ~err_q;

  always_comb begin
    sc_r   = '0;
    sc_cc  = '0;
    sc_err = 1'b0;
    case (op)
      4'd0: begin sc_r = a + b;                      sc_cc[0] = 1'b1; end
      4'd1: begin sc_r = a - b;                      sc_cc[0] = 1'b1; end
      4'd2: begin sc_r = {a[WIDTH-2:0], 1'b0};       sc_cc[0] = 1'b1; end
      4'd3: begin sc_r = {1'b0, a[WIDTH-1:1]};       sc_cc[0] = 1'b1; end
      4'd4: sc_r = a;
      4'd5: sc_r = b;
      4'd6: if (a >= b) begin sc_r = a; sc_cc[2] = 1'b1; end
            else        begin sc_r = b; sc_cc[3] = 1'b1; end
      4'd7: if (a < b)  begin sc_r = a; sc_cc[3] = 1'b1; end
            else        begin sc_r = b; sc_cc[2] = 1'b1; end
      default: sc_err = 1'b1;
    endcase
    sc_cc[1] = sc_cc[0] & (sc_r == '0);
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    r_d         = r_q;
    cc_d        = cc_q;
    err_d       = err_q;
`ifdef ALU_PIPE_MULDIV_EN
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    shf_d  = shf_q;
    div_d  = div_q;
`endif
    if ((state_q == HOLD) && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
    if (accept) begin
      state_d     = HOLD;
      out_valid_d = 1'b1;
      r_d         = sc_r;
      cc_d        = sc_cc;
      err_d       = sc_err;
`ifdef ALU_PIPE_MULDIV_EN
      if (start_iter) begin
        state_d     = ITER;
        out_valid_d = 1'b0;
        cnt_d       = '0;
        acc_d       = '0;
        opnd_d      = b;
        shf_d       = a;
        div_d       = op[0];
      end
`endif
    end
`ifdef ALU_PIPE_MULDIV_EN
    if (state_q == ITER) begin
      cnt_d  = cnt_q + CNT_W'(1);
      acc_d  = acc_nx;
      opnd_d = opnd_nx;
      shf_d  = shf_nx;
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d     = HOLD;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        if (div_q && (opnd_q == '0)) begin
          r_d   = '1;
          cc_d  = '0;
          err_d = 1'b1;
        end else begin
          r_d   = it_res;
          cc_d  = {2'b00, (it_res == '0), 1'b1};
          err_d = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      r_q         <= '0;
      cc_q        <= '0;
      err_q       <= 1'b0;
`ifdef ALU_PIPE_MULDIV_EN
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      shf_q  <= '0;
      div_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      cc_q        <= cc_d;
      err_q       <= err_d;
`ifdef ALU_PIPE_MULDIV_EN
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      shf_q  <= shf_d;
      div_q  <= div_d;
`endif
    end
  end

endmodule
